// File: rtl/text_console_writer.sv
// Character-stream writer for a text VRAM: cursor tracking, auto-wrap and row-offset scrolling.
// Optional TEXT_CONSOLE_CLR_ON_RESET_EN clears the whole screen after reset release.
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_din,
  output logic        vram_we,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic [4:0]  scroll_row,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: a byte transfers on a rising clk edge where ch_valid and ch_ready are both
  // high; ch_ready depends only on internal state, never on ch_valid.
  typedef enum logic [1:0] {IDLE, PUT, CLRLINE, CLRSCR} state_e;

  localparam logic [11:0] COLS_W  = 12'(COLS);
  localparam logic [11:0] CELLS_W = 12'(COLS * ROWS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0]  SPACE = 8'h20;

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  scroll_q, scroll_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [11:0] cnt_q, cnt_d;
  logic        nl_pend_q, nl_pend_d;

  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [4:0] scr,
                                            input logic [6:0] col);
    int phys;
    int full;
    phys = int'(row) + int'(scr);
    if (phys >= ROWS) phys = phys - ROWS;
    full = phys * COLS + int'(col);
    return full[11:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    scroll_d  = scroll_q;
    addr_d    = addr_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    nl_pend_d = nl_pend_q;
    we_d      = 1'b0;
    ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ch_valid && ready_q) begin
          ready_d = 1'b0;
          state_d = PUT;
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            we_d   = 1'b1;
            addr_d = cell_addr(row_q, scroll_q, col_q);
            din_d  = ch_data;
            if (col_q == LAST_COL) begin
              col_d = 7'd0;
              if (row_q < LAST_ROW) row_d = row_q + 5'd1;
              else nl_pend_d = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (ch_data)
              8'h0D: col_d = 7'd0;
              8'h0A: begin
                if (row_q < LAST_ROW) begin
                  row_d = row_q + 5'd1;
                end else begin
                  state_d = CLRLINE;
                  we_d    = 1'b1;
                  addr_d  = cell_addr(5'd0, scroll_q, 7'd0);
                  din_d   = SPACE;
                  cnt_d   = 12'd1;
                end
              end
              8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
              8'h0C: begin
                state_d = CLRSCR;
                we_d    = 1'b1;
                addr_d  = 12'd0;
                din_d   = SPACE;
                cnt_d   = 12'd1;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        // A wrap on the last row defers its line clear until after the character write.
        if (nl_pend_q) begin
          nl_pend_d = 1'b0;
          state_d   = CLRLINE;
          we_d      = 1'b1;
          addr_d    = cell_addr(5'd0, scroll_q, 7'd0);
          din_d     = SPACE;
          cnt_d     = 12'd1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      CLRLINE: begin
        if (cnt_q < COLS_W) begin
          we_d   = 1'b1;
          addr_d = cell_addr(5'd0, scroll_q, cnt_q[6:0]);
          din_d  = SPACE;
          cnt_d  = cnt_q + 12'd1;
          if (cnt_q == COLS_W - 12'd1)
            scroll_d = (scroll_q == LAST_ROW) ? 5'd0 : scroll_q + 5'd1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      CLRSCR: begin
        if (cnt_q < CELLS_W) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          din_d  = SPACE;
          cnt_d  = cnt_q + 12'd1;
        end else begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          col_d    = 7'd0;
          row_d    = 5'd0;
          scroll_d = 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLRLINE) || (state_d == CLRSCR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef TEXT_CONSOLE_CLR_ON_RESET_EN
      state_q <= CLRSCR;
      ready_q <= 1'b0;
`else
      state_q <= IDLE;
      ready_q <= 1'b1;
`endif
      col_q     <= 7'd0;
      row_q     <= 5'd0;
      scroll_q  <= 5'd0;
      addr_q    <= 12'd0;
      din_q     <= 8'd0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 12'd0;
      nl_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      col_q     <= col_d;
      row_q     <= row_d;
      scroll_q  <= scroll_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      nl_pend_q <= nl_pend_d;
    end
  end

  assign ch_ready   = ready_q;
  assign vram_addr  = addr_q;
  assign vram_din   = din_q;
  assign vram_we    = we_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign scroll_row = scroll_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: VRAM writes are scoreboarded against an expected queue.
module tb_text_console_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ch_data;
  logic        ch_valid;
  logic        ch_ready;
  logic [11:0] vram_addr;
  logic [7:0]  vram_din;
  logic        vram_we;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  scroll_row;
  logic        busy;
  logic [1:0]  state_dbg;

  logic [19:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  text_console_writer dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .vram_addr(vram_addr), .vram_din(vram_din), .vram_we(vram_we),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .scroll_row(scroll_row),
    .busy(busy), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (rst_n && vram_we) begin
      logic [19:0] e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write obs addr=%0d din=%0h exp none", vram_addr, vram_din);
      end else begin
        e = exp_q.pop_front();
        assert ({vram_addr, vram_din} === e) else begin
          errors++;
          $error("FAIL vram_write obs addr=%0d din=%0h exp addr=%0d din=%0h",
                 vram_addr, vram_din, e[19:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_addr(input int row, input int scr, input int col);
    return 12'(((row + scr) % 30) * 80 + col);
  endfunction

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_line(input int phys_row);
    for (int i = 0; i < 80; i++) push_wr(12'(phys_row * 80 + i), 8'h20);
  endtask

  task automatic push_screen();
    for (int i = 0; i < 2400; i++) push_wr(12'(i), 8'h20);
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!ch_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(ch_ready), 32'd1);
  endtask

  // Returns at posedge+1 of the cycle after the accept.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!ch_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ch_ready) begin
      errors++;
      $error("FAIL send_timeout obs ready=0 exp ready=1");
    end
    ch_valid = 1'b1;
    ch_data  = b;
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    ch_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_print(input int row, input int scr, input int col);
    logic [7:0] c;
    c = 8'($urandom_range(32'h20, 32'h7E));
    push_wr(model_addr(row, scr, col), c);
    send(c);
  endtask

  initial begin
    int w0;
    int bad;
    rst_n    = 1'b0;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_din", 32'(vram_din), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_scroll", 32'(scroll_row), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef TEXT_CONSOLE_CLR_ON_RESET_EN
    chk("rst_ready", 32'(ch_ready), 32'd0);
    push_screen();
    w0 = wr_cnt;
    rst_n = 1'b1;
    wait_ready(3000);
    chk("clr_on_reset_writes", 32'(wr_cnt - w0), 32'd2400);
`else
    chk("rst_ready", 32'(ch_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ch_ready), 32'd1);
`endif

    // Single 'A' from home.
    push_wr(12'd0, 8'h41);
    send(8'h41);
    @(negedge clk);
    chk("a_we", 32'(vram_we), 32'd1);
    chk("a_ready_low", 32'(ch_ready), 32'd0);
    chk("a_col", 32'(cursor_col), 32'd1);
    @(negedge clk);
    chk("a_ready_back", 32'(ch_ready), 32'd1);
    chk("a_we_one_cycle", 32'(vram_we), 32'd0);

    // Rest of row 0, wrap without a clear.
    for (int c = 1; c < 80; c++) send_print(0, 0, c);
    wait_ready(10);
    chk("row0_col", 32'(cursor_col), 32'd0);
    chk("row0_row", 32'(cursor_row), 32'd1);
    chk("row0_busy", 32'(busy), 32'd0);
    chk("row0_q_empty", 32'(exp_q.size()), 32'd0);

    // Walk down to the last row, then LF scrolls.
    for (int r = 0; r < 28; r++) send(8'h0A);
    wait_ready(10);
    chk("lf_row29", 32'(cursor_row), 32'd29);
    push_line(0);
    w0 = wr_cnt;
    send(8'h0A);
    @(negedge clk);
    chk("scroll_busy", 32'(busy), 32'd1);
    chk("scroll_ready_low", 32'(ch_ready), 32'd0);
    wait_ready(200);
    chk("scroll_writes", 32'(wr_cnt - w0), 32'd80);
    chk("scroll_row1", 32'(scroll_row), 32'd1);
    chk("scroll_row_stays", 32'(cursor_row), 32'd29);
    push_wr(12'd0, 8'h42);
    send(8'h42);
    wait_ready(10);
    chk("b_col", 32'(cursor_col), 32'd1);
    chk("b_q_empty", 32'(exp_q.size()), 32'd0);

    // CR, then four more scrolls to reach scroll_row=5.
    send(8'h0D);
    @(negedge clk);
    chk("cr_col", 32'(cursor_col), 32'd0);
    chk("cr_no_write", 32'(vram_we), 32'd0);
    for (int s = 1; s < 5; s++) begin
      push_line(s);
      send(8'h0A);
      wait_ready(200);
    end
    chk("scroll_row5", 32'(scroll_row), 32'd5);

    // BS at column 0 and an ignored code.
    w0 = wr_cnt;
    send(8'h08);
    @(negedge clk);
    chk("bs_col", 32'(cursor_col), 32'd0);
    chk("bs_no_write", 32'(vram_we), 32'd0);
    wait_ready(10);
    send(8'h07);
    @(negedge clk);
    chk("bel_no_write", 32'(vram_we), 32'd0);
    wait_ready(10);
    chk("bel_col", 32'(cursor_col), 32'd0);
    chk("bel_row", 32'(cursor_row), 32'd29);
    chk("bel_scroll", 32'(scroll_row), 32'd5);
    chk("ctrl_no_writes", 32'(wr_cnt - w0), 32'd0);

    // Form feed with a non-zero scroll offset.
    push_screen();
    w0 = wr_cnt;
    send(8'h0C);
    @(negedge clk);
    chk("ff_busy_first", 32'(busy), 32'd1);
    bad = 0;
    for (int i = 0; i < 2399; i++) begin
      @(negedge clk);
      if (!busy || ch_ready) bad++;
    end
    chk("ff_busy_throughout", 32'(bad), 32'd0);
    wait_ready(50);
    chk("ff_writes", 32'(wr_cnt - w0), 32'd2400);
    chk("ff_col", 32'(cursor_col), 32'd0);
    chk("ff_row", 32'(cursor_row), 32'd0);
    chk("ff_scroll", 32'(scroll_row), 32'd0);
    chk("ff_busy_end", 32'(busy), 32'd0);

    // Wrap on the last row triggers a scroll right behind the character write.
    for (int r = 0; r < 29; r++) send(8'h0A);
    for (int c = 0; c < 79; c++) send_print(29, 0, c);
    wait_ready(10);
    send_print(29, 0, 79);
    push_line(0);
    @(negedge clk);
    chk("wrap_we", 32'(vram_we), 32'd1);
    chk("wrap_busy_n1", 32'(busy), 32'd0);
    @(negedge clk);
    chk("wrap_clr_we", 32'(vram_we), 32'd1);
    chk("wrap_clr_busy", 32'(busy), 32'd1);
    chk("wrap_clr_ready", 32'(ch_ready), 32'd0);
    wait_ready(200);
    chk("wrap_scroll", 32'(scroll_row), 32'd1);
    chk("wrap_row", 32'(cursor_row), 32'd29);
    chk("wrap_col", 32'(cursor_col), 32'd0);
    chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a screen clear.
    push_screen();
    send(8'h0C);
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(vram_we), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_scroll", 32'(scroll_row), 32'd0);
    chk("abort_row", 32'(cursor_row), 32'd0);
    w0 = wr_cnt;
`ifdef TEXT_CONSOLE_CLR_ON_RESET_EN
    push_screen();
    rst_n = 1'b1;
    wait_ready(3000);
    chk("abort_writes", 32'(wr_cnt - w0), 32'd2400);
`else
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("abort_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("abort_ready", 32'(ch_ready), 32'd1);
`endif
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream writer for the 4096x8 text VRAM. Accepts bytes over a valid/ready handshake, interprets a small set of control codes, and drives one VRAM write port (address, data, write-enable) with cursor tracking, auto-wrap and hardware scrolling. Scrolling moves a row offset instead of copying memory. The display scanner on the other VRAM port applies `scroll_row` when it fetches rows.

## Interface
- `COLS`, 80, characters per row.
- `ROWS`, 30, rows per screen. `COLS*ROWS` must be ≤ 4096.
- `clk`  in  1  single clock; also clocks the VRAM write port.
- `rst_n`  in  1  asynchronous active-low reset.
- `ch_data`  in  8  input character.
- `ch_valid`  in  1  `ch_data` is valid.
- `ch_ready`  out  1  block can accept a character this cycle.
- `vram_addr`  out  12  VRAM write address.
- `vram_din`  out  8  VRAM write data.
- `vram_we`  out  1  VRAM write strobe.
- `cursor_col`  out  7  logical cursor column, range 0..COLS-1.
- `cursor_row`  out  5  logical cursor row, range 0..ROWS-1.
- `scroll_row`  out  5  physical row that is displayed as screen row 0.
- `busy`  out  1  high while a clear sequence is running.

## Operation
- States: IDLE, PUT, CLRLINE, CLRSCR.
- A character is accepted on any cycle where `ch_valid` and `ch_ready` are both high. `ch_ready` is high only in IDLE.
- Physical row is `(cursor_row + scroll_row) mod ROWS`.
- VRAM address is `phys_row*COLS + col`, computed at full width and truncated to 12 bits.
- Printable codes 0x20–0x7E: go to PUT. Write `ch_data` at the cursor address, then increment `cursor_col`.
  - If `cursor_col` was COLS-1: set column to 0 and perform a newline.
- 0x0D (CR): `cursor_col` ← 0. No write.
- 0x0A (LF): perform a newline. No character write.
- 0x08 (BS): if `cursor_col` > 0, decrement it. At column 0 there is no change. No write.
- 0x0C (FF): go to CLRSCR.
- All other codes are accepted and ignored, with no state change.
- Newline:
  - If `cursor_row` < ROWS-1: increment `cursor_row`.
  - Otherwise go to CLRLINE. Write 0x20 to the COLS cells of physical row `scroll_row`, columns 0..COLS-1 in order. On the final write, `scroll_row` ← `(scroll_row+1) mod ROWS`. `cursor_row` stays at ROWS-1.
- CLRSCR: write 0x20 to addresses 0..COLS*ROWS-1 in order. Then set `cursor_col` = `cursor_row` = `scroll_row` = 0 and return to IDLE.
- `busy` is high in CLRLINE and CLRSCR only.
- Reset values: `ch_ready`=1 (0 if the reset-clear option is enabled), `vram_we`=0, `vram_addr`=0, `vram_din`=0, `cursor_col`=0, `cursor_row`=0, `scroll_row`=0, `busy`=0.
- Reset asserted during any state aborts it immediately. `vram_we` drops asynchronously and no further writes occur.

## Timing
- All outputs are registered.
- Character accepted in cycle N:
  - Printable: `vram_we`=1 with address/data in cycle N+1. `ch_ready` is low in N+1 and high again in N+2. The cursor update is visible in N+1.
  - If the write triggers a scroll, CLRLINE starts in N+2 and `ch_ready` stays low.
- Control codes without a clear: the cursor update is visible in N+1. `ch_ready` is low in N+1 and high in N+2.
- CLRLINE: COLS consecutive write cycles. `ch_ready` rises the cycle after the last write.
- CLRSCR: COLS*ROWS consecutive write cycles, same rule for `ch_ready`.
- `vram_we` is asserted for exactly one cycle per cell written. There are no idle gaps inside a clear.
- `ch_data` is sampled only on the accept cycle. It may change freely otherwise.

## Configuration
- `TEXT_CONSOLE_CLR_ON_RESET_EN`
  - Defined: after reset deassertion the block enters CLRSCR (`busy`=1, `ch_ready`=0) and clears the whole screen before first accepting input.
  - Undefined: the block enters IDLE with `ch_ready`=1 and leaves VRAM contents untouched.

## Test plan
- Reset, macro undefined → all outputs equal their reset values. With the macro defined → exactly 2400 writes of 0x20 to addresses 0..2399, then `ch_ready`=1.
- Send 0x41 from home → one write: addr 0, din 0x41. `cursor_col`=1. `ch_ready` low for exactly one cycle.
- Send 80 printable chars on row 0 → last write at addr 79. Cursor ends at col 0, row 1. No clear occurs.
- At `cursor_row`=29, `scroll_row`=0, send LF → 80 writes of 0x20 to addr 0..79. `scroll_row` becomes 1 and `cursor_row` stays 29. A following 0x42 writes to addr 0 (physical row 0).
- With `scroll_row`=5, send FF → 2400 sequential writes of 0x20. Cursor and `scroll_row` all read 0. `busy` is high throughout.
- Send BS at col 0 → no write, cursor unchanged. Send 0x07 → accepted, no write, no state change.
- Assert `rst_n` mid-CLRSCR → `vram_we`=0 immediately and no writes occur after release (macro undefined).
